// File: rtl/and_reduce_pkg.sv
// Shared constants and elaboration-time helpers for the pipelined reduction gate.
// Tree geometry: level k has level_nodes(k) nodes, and the outputs of all levels are packed into one vector.
package and_reduce_pkg;

    localparam logic [1:0] MODE_AND = 2'b00;
    localparam logic [1:0] MODE_OR  = 2'b01;
    localparam logic [1:0] MODE_INV = 2'b10;

    // Enough levels for WIDTH=256 at FANIN=2, with margin.
    localparam int MAX_LEVELS = 16;

    function automatic int num_stages(input int width, input int fanin);
        int n;
        int s;
        n = width;
        s = 0;
        for (int k = 0; k < MAX_LEVELS; k++) begin
            if (n > 1) begin
                n = (n + fanin - 1) / fanin;
                s++;
            end
        end
        return (s < 1) ? 1 : s;
    endfunction

    // Node count of level k; level 0 reduces the WIDTH raw inputs.
    function automatic int level_nodes(input int width, input int fanin, input int k);
        int n;
        n = width;
        for (int j = 0; j < MAX_LEVELS; j++) begin
            if (j <= k) n = (n + fanin - 1) / fanin;
        end
        return n;
    endfunction

    // Bit offset of level k's outputs inside the packed tree vector.
    function automatic int level_offset(input int width, input int fanin, input int k);
        int off;
        off = 0;
        for (int j = 0; j < MAX_LEVELS; j++) begin
            if (j < k) off += level_nodes(width, fanin, j);
        end
        return off;
    endfunction

    // Value that leaves the reduction unchanged: 1 for AND, 0 for OR.
    function automatic logic identity(input logic [1:0] mode);
        return ((mode & MODE_OR) == 2'b00);
    endfunction

endpackage

// File: rtl/and_reduce_pipe_reduce_level.sv
// One registered level of the reduction tree: N_OUT nodes of FANIN inputs each.
// The last level also applies the output inversion and resets to the block's INIT value.
module reduce_level
    import and_reduce_pkg::*;
#(
    parameter int   N_IN    = 16,
    parameter int   N_OUT   = 4,
    parameter int   FANIN   = 4,
    parameter bit   LAST    = 1'b0,
    parameter logic RST_VAL = 1'b0
) (
    input  logic             C,
    input  logic             CLR_N,
    input  logic             CE,
    input  logic [N_IN-1:0]  d_i,
    input  logic [1:0]       mode_i,
    output logic [N_OUT-1:0] q_o
);

    logic [N_OUT-1:0] red;
    logic [N_OUT-1:0] q_d;
    logic [N_OUT-1:0] q_q;
    logic             inv;

    for (genvar n = 0; n < N_OUT; n++) begin : g_node
        logic [FANIN-1:0] leaf;
        for (genvar j = 0; j < FANIN; j++) begin : g_leaf
            if (n * FANIN + j < N_IN) begin : g_use
                assign leaf[j] = d_i[n*FANIN+j];
            end else begin : g_pad
                assign leaf[j] = identity(mode_i);
            end
        end
        assign red[n] = mode_i[0] ? (|leaf) : (&leaf);
    end

    assign inv = LAST && ((mode_i & MODE_INV) != 2'b00);
    assign q_d = red ^ {N_OUT{inv}};

    always_ff @(posedge C or negedge CLR_N) begin
        if (!CLR_N) begin
            q_q <= {N_OUT{RST_VAL}};
        end else if (CE) begin
            q_q <= q_d;
        end
    end

    assign q_o = q_q;

endmodule

// File: rtl/and_reduce_pipe.sv
// Pipelined WIDTH-input AND/OR/NAND/NOR reduction, one register per FANIN-ary tree level.
// Optional per-bit MASK port when AND_REDUCE_PIPE_MASK_EN is defined.
module and_reduce_pipe
    import and_reduce_pkg::*;
#(
    parameter int   WIDTH = 16,
    parameter int   FANIN = 4,
    parameter logic INIT  = 1'b0
) (
    input  logic             C,
    input  logic             CLR_N,
    input  logic             CE,
    input  logic             VALID_IN,
    input  logic [1:0]       MODE,
    input  logic [WIDTH-1:0] I,
`ifdef AND_REDUCE_PIPE_MASK_EN
    input  logic [WIDTH-1:0] MASK,
`endif
    output logic             VALID_OUT,
    output logic             O
);

    localparam int STAGES = num_stages(WIDTH, FANIN);
    localparam int TREE_W = level_offset(WIDTH, FANIN, STAGES);

    logic [WIDTH-1:0]            lvl0;
    logic [TREE_W-1:0]           tree;
    logic [STAGES-1:0][1:0]      mode_pipe;
    logic [STAGES:1]             vld_pipe;

`ifdef AND_REDUCE_PIPE_MASK_EN
    // Masked bits become the identity of this sample's mode, so they never decide the result.
    for (genvar b = 0; b < WIDTH; b++) begin : g_mask
        assign lvl0[b] = MASK[b] ? identity(MODE) : I[b];
    end
`else
    assign lvl0 = I;
`endif

    // Each level reduces under the mode of the sample it is currently holding.
    assign mode_pipe[0] = MODE;
    if (STAGES > 1) begin : g_mode
        logic [STAGES-1:1][1:0] mode_q;
        always_ff @(posedge C or negedge CLR_N) begin
            if (!CLR_N) begin
                mode_q <= '0;
            end else if (CE) begin
                mode_q[1] <= MODE;
                for (int k = 2; k < STAGES; k++) mode_q[k] <= mode_q[k-1];
            end
        end
        assign mode_pipe[STAGES-1:1] = mode_q;
    end

    always_ff @(posedge C or negedge CLR_N) begin
        if (!CLR_N) begin
            vld_pipe <= '0;
        end else if (CE) begin
            vld_pipe[1] <= VALID_IN;
            for (int k = 2; k <= STAGES; k++) vld_pipe[k] <= vld_pipe[k-1];
        end
    end

    for (genvar k = 0; k < STAGES; k++) begin : g_lvl
        localparam int NI    = (k == 0) ? WIDTH : level_nodes(WIDTH, FANIN, k - 1);
        localparam int NO    = level_nodes(WIDTH, FANIN, k);
        localparam int OFF_O = level_offset(WIDTH, FANIN, k);
        localparam int OFF_I = (k == 0) ? 0 : level_offset(WIDTH, FANIN, k - 1);

        logic [NI-1:0] din;
        if (k == 0) begin : g_first
            assign din = lvl0;
        end else begin : g_next
            assign din = tree[OFF_I +: NI];
        end

        reduce_level #(
            .N_IN   (NI),
            .N_OUT  (NO),
            .FANIN  (FANIN),
            .LAST   (k == STAGES - 1),
            .RST_VAL((k == STAGES - 1) ? INIT : 1'b0)
        ) u_lvl (
            .C      (C),
            .CLR_N  (CLR_N),
            .CE     (CE),
            .d_i    (din),
            .mode_i (mode_pipe[k]),
            .q_o    (tree[OFF_O +: NO])
        );
    end

    // The final level always has exactly one node, at the top of the packed tree.
    assign O         = tree[TREE_W-1];
    assign VALID_OUT = vld_pipe[STAGES];

endmodule

// File: tb/tb_and_reduce_pipe.sv
// Directed bench for and_reduce_pipe: WIDTH=16 (2 stages), WIDTH=5 (partial tree), WIDTH=1 (1 stage).
// Mask checks are compiled in when AND_REDUCE_PIPE_MASK_EN is defined.
module tb_and_reduce_pipe;

    logic        C = 1'b0;
    logic        CLR_N, CE, VALID_IN;
    logic [1:0]  MODE;
    logic [15:0] I16;
    logic [4:0]  I5;
    logic [0:0]  I1;
`ifdef AND_REDUCE_PIPE_MASK_EN
    logic [15:0] M16;
    logic [4:0]  M5;
    logic [0:0]  M1;
`endif
    logic v16, o16, v5, o5, v1, o1;

    int total = 0;
    int bad   = 0;

    always #5 C = ~C;

    and_reduce_pipe #(.WIDTH(16), .FANIN(4), .INIT(1'b1)) dut16 (
        .C(C), .CLR_N(CLR_N), .CE(CE), .VALID_IN(VALID_IN), .MODE(MODE), .I(I16),
`ifdef AND_REDUCE_PIPE_MASK_EN
        .MASK(M16),
`endif
        .VALID_OUT(v16), .O(o16));

    and_reduce_pipe #(.WIDTH(5), .FANIN(4), .INIT(1'b0)) dut5 (
        .C(C), .CLR_N(CLR_N), .CE(CE), .VALID_IN(VALID_IN), .MODE(MODE), .I(I5),
`ifdef AND_REDUCE_PIPE_MASK_EN
        .MASK(M5),
`endif
        .VALID_OUT(v5), .O(o5));

    and_reduce_pipe #(.WIDTH(1), .FANIN(4), .INIT(1'b1)) dut1 (
        .C(C), .CLR_N(CLR_N), .CE(CE), .VALID_IN(VALID_IN), .MODE(MODE), .I(I1),
`ifdef AND_REDUCE_PIPE_MASK_EN
        .MASK(M1),
`endif
        .VALID_OUT(v1), .O(o1));

    typedef struct {
        logic [1:0]  mode;
        logic [15:0] i16;
        logic        e16;
        logic [4:0]  i5;
        logic        e5;
        logic        i1;
        logic        e1;
    } vec_t;

    vec_t tbl[12];

    task automatic chk(input string nm, input logic act, input logic exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %b want %b", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge C);
        #1;
    endtask

    task automatic drive(input logic vld, input logic [1:0] m, input logic [15:0] a,
                         input logic [4:0] b, input logic c);
        VALID_IN = vld;
        MODE     = m;
        I16      = a;
        I5       = b;
        I1       = c;
    endtask

    initial begin
        //          mode   i16       e16   i5        e5    i1    e1
        tbl[0]  = '{2'b00, 16'hFFFF, 1'b1, 5'b11111, 1'b1, 1'b1, 1'b1};
        tbl[1]  = '{2'b00, 16'hFFFE, 1'b0, 5'b11110, 1'b0, 1'b0, 1'b0};
        tbl[2]  = '{2'b10, 16'hFFFE, 1'b1, 5'b01111, 1'b1, 1'b1, 1'b0};
        tbl[3]  = '{2'b01, 16'h0000, 1'b0, 5'b00000, 1'b0, 1'b0, 1'b0};
        tbl[4]  = '{2'b01, 16'h0100, 1'b1, 5'b10000, 1'b1, 1'b1, 1'b1};
        tbl[5]  = '{2'b11, 16'h0000, 1'b1, 5'b00000, 1'b1, 1'b0, 1'b1};
        tbl[6]  = '{2'b01, 16'h8000, 1'b1, 5'b00001, 1'b1, 1'b0, 1'b0};
        tbl[7]  = '{2'b00, 16'h7FFF, 1'b0, 5'b01111, 1'b0, 1'b1, 1'b1};
        tbl[8]  = '{2'b10, 16'hFFFF, 1'b0, 5'b11111, 1'b0, 1'b1, 1'b0};
        tbl[9]  = '{2'b11, 16'h0001, 1'b0, 5'b10000, 1'b0, 1'b1, 1'b0};
        tbl[10] = '{2'b00, 16'h0000, 1'b0, 5'b11101, 1'b0, 1'b1, 1'b1};
        tbl[11] = '{2'b01, 16'h0000, 1'b0, 5'b00000, 1'b0, 1'b0, 1'b0};

        CLR_N = 1'b1;
        CE    = 1'b1;
        drive(1'b0, 2'b00, 16'h0000, 5'b0, 1'b0);
`ifdef AND_REDUCE_PIPE_MASK_EN
        M16 = '0; M5 = '0; M1 = '0;
`endif
        // Asynchronous clear before any clock edge.
        #1 CLR_N = 1'b0;
        #1;
        chk("rst_o16_init", o16, 1'b1);
        chk("rst_v16", v16, 1'b0);
        chk("rst_o5_init", o5, 1'b0);
        chk("rst_v5", v5, 1'b0);
        chk("rst_o1_init", o1, 1'b1);
        step();
        CLR_N = 1'b1;

        // First sample after release: latency 2 for 16/5 bits, 1 for the 1-bit gate.
        drive(1'b1, 2'b00, 16'hFFFF, 5'b11111, 1'b1);
        step();
        drive(1'b0, 2'b00, 16'h0000, 5'b0, 1'b0);
        chk("first_v16_early", v16, 1'b0);
        chk("first_v1", v1, 1'b1);
        chk("first_o1", o1, 1'b1);
        step();
        chk("first_v16", v16, 1'b1);
        chk("first_o16", o16, 1'b1);
        chk("first_v5", v5, 1'b1);
        chk("first_o5", o5, 1'b1);
        step();
        step();

        // Back-to-back streaming with mixed modes.
        for (int n = 0; n <= 12; n++) begin
            if (n < 12) drive(1'b1, tbl[n].mode, tbl[n].i16, tbl[n].i5, tbl[n].i1);
            else        drive(1'b0, 2'b00, 16'h0000, 5'b0, 1'b0);
            step();
            if (n < 12) begin
                chk($sformatf("tbl%0d_o1", n), o1, tbl[n].e1);
                chk($sformatf("tbl%0d_v1", n), v1, 1'b1);
            end else begin
                chk("tbl_end_v1", v1, 1'b0);
            end
            if (n >= 1) begin
                chk($sformatf("tbl%0d_o16", n - 1), o16, tbl[n-1].e16);
                chk($sformatf("tbl%0d_v16", n - 1), v16, 1'b1);
                chk($sformatf("tbl%0d_o5", n - 1), o5, tbl[n-1].e5);
                chk($sformatf("tbl%0d_v5", n - 1), v5, 1'b1);
            end
        end
        step();
        chk("tbl_end_v16", v16, 1'b0);
        chk("tbl_end_v5", v5, 1'b0);

        // CE stall with a sample held in level 0.
        drive(1'b0, 2'b00, 16'hFFFE, 5'b0, 1'b0);
        step();
        step();
        chk("stall_pre_o16", o16, 1'b0);
        drive(1'b1, 2'b00, 16'hFFFF, 5'b0, 1'b0);
        step();
        drive(1'b0, 2'b00, 16'h0000, 5'b0, 1'b0);
        CE = 1'b0;
        for (int s = 0; s < 3; s++) begin
            step();
            chk($sformatf("stall%0d_o16", s), o16, 1'b0);
            chk($sformatf("stall%0d_v16", s), v16, 1'b0);
        end
        CE = 1'b1;
        step();
        chk("stall_resume_o16", o16, 1'b1);
        chk("stall_resume_v16", v16, 1'b1);
        step();
        chk("stall_after_v16", v16, 1'b0);
        step();

        // Same stall, but the clear lands while the sample is held: it must vanish.
        drive(1'b1, 2'b00, 16'hFFFE, 5'b0, 1'b0);
        step();
        drive(1'b0, 2'b00, 16'h0000, 5'b0, 1'b0);
        CE = 1'b0;
        step();
        #2 CLR_N = 1'b0;
        #1;
        chk("midclr_o16_init", o16, 1'b1);
        chk("midclr_v16", v16, 1'b0);
        step();
        CLR_N = 1'b1;
        step();
        CE = 1'b1;
        for (int s = 0; s < 3; s++) begin
            step();
            chk($sformatf("midclr%0d_v16", s), v16, 1'b0);
        end

`ifdef AND_REDUCE_PIPE_MASK_EN
        M16 = 16'hFF00;
        drive(1'b1, 2'b00, 16'h00FF, 5'b0, 1'b0);
        M5 = 5'h1F;
        step();
        step();
        chk("mask_and_o16", o16, 1'b1);
        chk("mask_all_and_o5", o5, 1'b1);
        M16 = 16'hFFFF;
        drive(1'b1, 2'b01, 16'hFFFF, 5'h1F, 1'b0);
        step();
        step();
        chk("mask_all_or_o16", o16, 1'b0);
        chk("mask_all_or_o5", o5, 1'b0);
        M16 = 16'h0000;
        M5  = 5'h00;
        drive(1'b1, 2'b00, 16'h00FF, 5'b0, 1'b0);
        step();
        step();
        chk("mask_off_and_o16", o16, 1'b0);
        VALID_IN = 1'b0;
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
